axi_beat_scoreboard: RTL

Synthesizable, passive AXI4 beat scoreboard that taps the upstream (master-side) and downstream (slave-side) data channels of an AXI passthrough and checks that every R and W beat crosses it unchanged and in order. Per side and channel, beats are buffered in a parametrised FIFO and compared pairwise. Comparison and error counts are exported for status registers. It sits beside the AXI interconnect/passthrough in the FM validation design and never drives bus handshakes.

---
 rtl/axi_beat_scoreboard.sv | 206 ++++++++++++++++++++
 1 files changed

// File: rtl/axi_beat_scoreboard.sv
// Passive AXI4 beat scoreboard: pairs upstream (m_) and downstream (s_) R/W beats in order and
// counts matches/mismatches. Define AXI_SCB_TIMEOUT_EN to build the unmatched-beat timeout.
module axi_beat_scoreboard #(
    parameter int unsigned DATA_W      = 32,
    parameter int unsigned ID_W        = 4,
    parameter int unsigned DEPTH       = 16,
    parameter int unsigned CNT_W       = 32,
    parameter int unsigned TIMEOUT_CYC = 1024
) (
    input  logic                  aclk,
    input  logic                  aresetn,
    input  logic                  m_rvalid,
    input  logic                  m_rready,
    input  logic                  m_rlast,
    input  logic [DATA_W-1:0]     m_rdata,
    input  logic [ID_W-1:0]       m_rid,
    input  logic [1:0]            m_rresp,
    input  logic                  m_wvalid,
    input  logic                  m_wready,
    input  logic                  m_wlast,
    input  logic [DATA_W-1:0]     m_wdata,
    input  logic [DATA_W/8-1:0]   m_wstrb,
    input  logic                  s_rvalid,
    input  logic                  s_rready,
    input  logic                  s_rlast,
    input  logic [DATA_W-1:0]     s_rdata,
    input  logic [ID_W-1:0]       s_rid,
    input  logic [1:0]            s_rresp,
    input  logic                  s_wvalid,
    input  logic                  s_wready,
    input  logic                  s_wlast,
    input  logic [DATA_W-1:0]     s_wdata,
    input  logic [DATA_W/8-1:0]   s_wstrb,
    input  logic                  clr,
    output logic [CNT_W-1:0]      cmp_cnt,
    output logic [CNT_W-1:0]      err_cnt,
    output logic                  err_pulse,
    output logic [1:0]            err_chan,
    output logic [1:0]            ovf,
    output logic [1:0]            tmo,
    output logic                  busy
);
    localparam int unsigned RW = DATA_W + ID_W + 3;
    localparam int unsigned WW = DATA_W + DATA_W / 8 + 1;
    localparam int unsigned EW = (RW > WW) ? RW : WW;
    localparam int unsigned AW = $clog2(DEPTH);
    localparam logic [AW-1:0] PTR_ONE  = 1;
    localparam logic [AW:0]   CNT_ONE  = 1;
    localparam logic [AW:0]   CNT_FULL = (AW + 1)'(DEPTH);

    // FIFO index: 0 = m W, 1 = s W, 2 = m R, 3 = s R; channel 0 = W, channel 1 = R.
    logic [EW-1:0] mem_q [4][DEPTH];
    logic [EW-1:0] wr_data [4];
    logic [EW-1:0] head [4];
    logic [AW-1:0] wptr_q [4], wptr_d [4], rptr_q [4], rptr_d [4];
    logic [AW:0]   fcnt_q [4], fcnt_d [4];
    logic [3:0]    push, pop, we, nempty, full;
    logic [1:0]    pop_ch, mis, ovf_set, n_cmp, n_mis;

    logic [1:0]       cmp_vld_q, cmp_vld_d, err_chan_q, err_chan_d, ovf_q, ovf_d;
    logic             err_pulse_q, err_pulse_d;
    logic [CNT_W-1:0] cmp_cnt_q, cmp_cnt_d, err_cnt_q, err_cnt_d;

    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] a, input logic [1:0] b);
        logic [CNT_W:0] s;
        s = {1'b0, a} + (CNT_W + 1)'(b);
        return s[CNT_W] ? '1 : s[CNT_W-1:0];
    endfunction

    assign push = {s_rvalid & s_rready, m_rvalid & m_rready, s_wvalid & s_wready,
                   m_wvalid & m_wready};

    always_comb begin
        for (int i = 0; i < 4; i++) wr_data[i] = '0;
        wr_data[0][WW-1:0] = {m_wdata, m_wstrb, m_wlast};
        wr_data[1][WW-1:0] = {s_wdata, s_wstrb, s_wlast};
        wr_data[2][RW-1:0] = {m_rdata, m_rid, m_rresp, m_rlast};
        wr_data[3][RW-1:0] = {s_rdata, s_rid, s_rresp, s_rlast};
    end

    always_comb begin
        for (int i = 0; i < 4; i++) begin
            nempty[i] = fcnt_q[i] != '0;
            full[i]   = fcnt_q[i] == CNT_FULL;
            head[i]   = mem_q[i][rptr_q[i]];
        end
        for (int c = 0; c < 2; c++) begin
            pop_ch[c]    = nempty[2*c] && nempty[2*c+1];
            pop[2*c]     = pop_ch[c];
            pop[2*c+1]   = pop_ch[c];
            mis[c]       = pop_ch[c] && (head[2*c] != head[2*c+1]);
            // A pop frees a slot in the same cycle, so a push into a full FIFO is kept then.
            ovf_set[c]   = (push[2*c] && full[2*c] && !pop[2*c]) ||
                           (push[2*c+1] && full[2*c+1] && !pop[2*c+1]);
        end
        for (int i = 0; i < 4; i++) begin
            we[i]     = push[i] && (!full[i] || pop[i]) && !clr;
            wptr_d[i] = wptr_q[i];
            rptr_d[i] = rptr_q[i];
            fcnt_d[i] = fcnt_q[i];
            if (clr) begin
                wptr_d[i] = '0;
                rptr_d[i] = '0;
                fcnt_d[i] = '0;
            end else begin
                if (we[i])  wptr_d[i] = wptr_q[i] + PTR_ONE;
                if (pop[i]) rptr_d[i] = rptr_q[i] + PTR_ONE;
                case ({we[i], pop[i]})
                    2'b10:   fcnt_d[i] = fcnt_q[i] + CNT_ONE;
                    2'b01:   fcnt_d[i] = fcnt_q[i] - CNT_ONE;
                    default: fcnt_d[i] = fcnt_q[i];
                endcase
            end
        end
        n_cmp       = {1'b0, pop_ch[0]} + {1'b0, pop_ch[1]};
        n_mis       = {1'b0, mis[0]} + {1'b0, mis[1]};
        cmp_vld_d   = clr ? 2'b00 : pop_ch;
        err_chan_d  = clr ? 2'b00 : mis;
        err_pulse_d = !clr && (|mis);
        cmp_cnt_d   = clr ? '0 : sat_add(cmp_cnt_q, n_cmp);
        err_cnt_d   = clr ? '0 : sat_add(err_cnt_q, n_mis);
        ovf_d       = clr ? 2'b00 : (ovf_q | ovf_set);
    end

    always_ff @(posedge aclk) begin
        for (int i = 0; i < 4; i++) begin
            if (we[i]) mem_q[i][wptr_q[i]] <= wr_data[i];
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            for (int i = 0; i < 4; i++) begin
                wptr_q[i] <= '0;
                rptr_q[i] <= '0;
                fcnt_q[i] <= '0;
            end
            cmp_vld_q   <= 2'b00;
            err_chan_q  <= 2'b00;
            err_pulse_q <= 1'b0;
            cmp_cnt_q   <= '0;
            err_cnt_q   <= '0;
            ovf_q       <= 2'b00;
        end else begin
            for (int i = 0; i < 4; i++) begin
                wptr_q[i] <= wptr_d[i];
                rptr_q[i] <= rptr_d[i];
                fcnt_q[i] <= fcnt_d[i];
            end
            cmp_vld_q   <= cmp_vld_d;
            err_chan_q  <= err_chan_d;
            err_pulse_q <= err_pulse_d;
            cmp_cnt_q   <= cmp_cnt_d;
            err_cnt_q   <= err_cnt_d;
            ovf_q       <= ovf_d;
        end
    end

`ifdef AXI_SCB_TIMEOUT_EN
    localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [TW-1:0] TMO_LIM = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] TMO_ONE = 1;
    logic [TW-1:0] tcnt_q [2], tcnt_d [2];
    logic [1:0]    tmo_q, tmo_d;

    // Counts only while one side is waiting for its partner; saturates at the limit.
    always_comb begin
        for (int c = 0; c < 2; c++) begin
            tcnt_d[c] = tcnt_q[c];
            tmo_d[c]  = tmo_q[c];
            if (clr) begin
                tcnt_d[c] = '0;
                tmo_d[c]  = 1'b0;
            end else if (nempty[2*c] ^ nempty[2*c+1]) begin
                if (tcnt_q[c] != TMO_LIM) tcnt_d[c] = tcnt_q[c] + TMO_ONE;
                if (tcnt_d[c] == TMO_LIM) tmo_d[c] = 1'b1;
            end else begin
                tcnt_d[c] = '0;
            end
        end
    end

    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            tcnt_q[0] <= '0;
            tcnt_q[1] <= '0;
            tmo_q     <= 2'b00;
        end else begin
            tcnt_q[0] <= tcnt_d[0];
            tcnt_q[1] <= tcnt_d[1];
            tmo_q     <= tmo_d;
        end
    end

    assign tmo = tmo_q;
`else
    assign tmo = 2'b00;
`endif

    assign cmp_cnt   = cmp_cnt_q;
    assign err_cnt   = err_cnt_q;
    assign err_pulse = err_pulse_q;
    assign err_chan  = err_chan_q;
    assign ovf       = ovf_q;
    assign busy      = (|nempty) || (|cmp_vld_q);
endmodule
